// File: rtl/reg_wr_arbiter_if.sv
// Requester-side bus of the shared-register write arbiter.
interface reg_wr_arbiter_if #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 4
);
  localparam int unsigned IW = $clog2(N);

  logic [N-1:0]   REQ;
  logic [N*W-1:0] WDATA;
  logic [N-1:0]   GNT;
  logic [N-1:0]   ACK;
  logic [IW-1:0]  GID;
  logic           BUSY;
  logic [W-1:0]   Q;

  modport master (
    output REQ, WDATA,
    input  GNT, ACK, GID, BUSY, Q
  );

  modport slave (
    input  REQ, WDATA,
    output GNT, ACK, GID, BUSY, Q
  );
endinterface

// File: rtl/reg_wr_arbiter.sv
// Round-robin write arbiter owning a shared W-bit register.
// One transaction is IDLE -> GRANT -> COMMIT; the register is written on the
// GRANT -> COMMIT edge only if the grantee still holds its request.
module reg_wr_arbiter #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 4
) (
  input  logic            CK,
  input  logic            RST,
  reg_wr_arbiter_if.slave bus
);

  localparam int unsigned IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [IW-1:0]   gid, gid_nxt;
  logic [N-1:0]    gnt, gnt_nxt;
  logic [N-1:0]    ack, ack_nxt;
  logic [W-1:0]    q, q_nxt;
  logic            busy, busy_nxt;

  logic [IW-1:0]   win;
  logic [IW-1:0]   idx;
  logic            win_vld;
  logic [W-1:0]    slice [N];

  // Split the flat data bus into per-requester slices.
  for (genvar gi = 0; gi < N; gi++) begin : g_slice
    assign slice[gi] = bus.WDATA[gi*W +: W];
  end

  // Round-robin scan starting at the priority pointer; first active request wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IW'((32'(ptr) + i) % N);
      if (!win_vld && bus.REQ[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gid_nxt   = gid;
    gnt_nxt   = gnt;
    ack_nxt   = '0;
    q_nxt     = q;
    case (state)
      IDLE: begin
        if (win_vld) begin
          gnt_nxt   = N'(1) << win;
          gid_nxt   = win;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        gnt_nxt = '0;
        if (bus.REQ[gid]) begin
          q_nxt     = slice[gid];
          ack_nxt   = N'(1) << gid;
          state_nxt = COMMIT;
        end else begin
          // Grantee withdrew: drop the grant without writing or advancing priority.
          state_nxt = IDLE;
        end
      end
      COMMIT: begin
        ptr_nxt   = (gid == IW'(N - 1)) ? '0 : gid + IW'(1);
        state_nxt = IDLE;
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge CK) begin
    if (RST) begin
      state <= IDLE;
      ptr   <= '0;
      gid   <= '0;
      gnt   <= '0;
      ack   <= '0;
      q     <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gid   <= gid_nxt;
      gnt   <= gnt_nxt;
      ack   <= ack_nxt;
      q     <= q_nxt;
      busy  <= busy_nxt;
    end
  end

  assign bus.GNT  = gnt;
  assign bus.ACK  = ack;
  assign bus.GID  = gid;
  assign bus.BUSY = busy;
  assign bus.Q    = q;

endmodule
